ps2_key_rx: RTL and testbench

Deserialises the raw PS/2 keyboard clock/data lines into the 11-bit `ps2_key` event word consumed by the CPC keyboard/HID matrix logic. It is the producer end of that interface. It sits between the board PS/2 pins, or the framework's PS/2 pass-through, and the `hid` input block. It handles line synchronisation, glitch filtering, frame checking, and the E0/F0/E1 prefix bytes, and emits exactly one toggled event per completed make or break code.

---
 rtl/ps2_key_rx_if.sv | 19 +
 rtl/ps2_key_rx.sv | 179 +++++++++++++++++
 tb/tb_ps2_key_rx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_rx_if.sv
// PS/2 line inputs and decoded key-event outputs of ps2_key_rx.
// master = the receiver producing ps2_key; slave = pins/consumer side.
interface ps2_key_rx_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    modport master (
        input  ps2_clk, ps2_data,
        output ps2_key, frame_err, busy
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  ps2_key, frame_err, busy
    );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame FSM, and
// E0/F0/E1 prefix decoding into a toggle-flagged 11-bit key event word.
module ps2_key_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic         clk,
    input  logic         reset,
    ps2_key_rx_if.master bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;
    localparam int         TW       = $clog2(TIMEOUT + 1);

    // Index 0 = clock line, index 1 = data line.
    logic [1:0]      r_sync0;
    logic [1:0]      r_sync1;
    logic [1:0]      r_flt;
    logic [1:0][7:0] r_fcnt;
    logic            r_clk_prev;
    logic            w_fall;
    logic            w_bit;

    logic [1:0]      r_state;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [TW-1:0]   r_tcnt;
    logic            r_byte_rdy;
    logic            r_frame_err;
    logic            w_tout;

    logic [10:0]     r_key;
    logic            r_ext;
    logic            r_brk;
    logic [2:0]      r_skip;
    logic            w_resp;

    // Lines idle high, so the synchronisers and filters come out of reset at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync0 <= 2'b11;
            r_sync1 <= 2'b11;
        end else begin
            r_sync0 <= {bus.ps2_data, bus.ps2_clk};
            r_sync1 <= r_sync0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flt      <= 2'b11;
            r_fcnt     <= '0;
            r_clk_prev <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync1[i] != r_flt[i]) begin
                    if (r_fcnt[i] == 8'(FILTER - 1)) begin
                        r_flt[i]  <= r_sync1[i];
                        r_fcnt[i] <= '0;
                    end else begin
                        r_fcnt[i] <= r_fcnt[i] + 8'd1;
                    end
                end else begin
                    r_fcnt[i] <= '0;
                end
            end
            r_clk_prev <= r_flt[0];
        end
    end

    assign w_fall = r_clk_prev & ~r_flt[0];
    assign w_bit  = r_flt[1];

    // r_tcnt holds the number of cycles since the last fall, so the abort
    // lands exactly TIMEOUT cycles after that fall.
    assign w_tout = (r_state != S_IDLE) && !w_fall && (r_tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_tcnt      <= '0;
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_fall)
                r_tcnt <= TW'(1);
            else if (r_state == S_IDLE)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + TW'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        if (!w_bit) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_fall) begin
                        r_shift  <= {w_bit, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7)
                            r_state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (w_fall) begin
                        r_par   <= w_bit;
                        r_state <= S_STOP;
                    end
                end
                default: begin
                    if (w_fall) begin
                        if (w_bit && (^{r_shift, r_par}))
                            r_byte_rdy <= 1'b1;
                        else
                            r_frame_err <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
            endcase

            if (w_tout) begin
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
            end
        end
    end

    // Controller responses / error codes, dropped only when no prefix is pending.
    assign w_resp = (r_shift == 8'hFA) || (r_shift == 8'hAA) || (r_shift == 8'hEE) ||
                    (r_shift == 8'hFE) || (r_shift == 8'h00) || (r_shift == 8'hFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key  <= '0;
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= '0;
        end else if (r_frame_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_byte_rdy) begin
            if (r_skip != 3'd0) begin
                r_skip <= r_skip - 3'd1;
            end else if (r_shift == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_shift == 8'hF0) begin
                r_brk <= 1'b1;
            end else if (r_shift == 8'hE1) begin
                r_skip <= 3'd7;
            end else if (!(w_resp && !r_ext && !r_brk)) begin
                r_key <= {~r_key[10], r_brk, r_ext, r_shift};
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    assign bus.ps2_key   = r_key;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: make/break, extended, errors, timeout,
// Pause/response suppression, glitch rejection and mid-frame reset.
module tb_ps2_key_rx;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_key_rx_if bus();

    ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   toggles = 0;
    int   fe_pulses = 0;
    int   fe_hi = 0;
    logic prev_k10 = 1'b0;
    logic prev_fe = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            if (bus.ps2_key[10] !== prev_k10) toggles++;
            if (bus.frame_err === 1'b1) fe_hi++;
            if (bus.frame_err === 1'b1 && !prev_fe) fe_pulses++;
            prev_k10 = bus.ps2_key[10];
            prev_fe  = bus.frame_err;
        end else begin
            prev_k10 = 1'b0;
            prev_fe  = 1'b0;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit: data set while clock high, device drives clock low then high.
    // A glitch is a 3-cycle low pulse on the clock during its high phase.
    task automatic ps2_bit(input logic b, input bit glitch = 1'b0);
        bus.ps2_data = b;
        if (glitch) begin
            repeat (12) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (HALF - 15) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0,
                             input bit glitch = 1'b0);
        logic par;
        par = bad_par ? (^b) : ~(^b);
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
        ps2_bit(par, glitch);
        ps2_bit(1'b1, glitch);
        bus.ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    int   t0;
    int   f0;
    int   h0;
    int   lat;
    bit   got;
    logic busy_mid;

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_key", int'(bus.ps2_key), 0);
        check("rst_ferr", int'(bus.frame_err), 0);
        check("rst_busy", int'(bus.busy), 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // Make then break of 1C
        t0 = toggles;
        send_byte(8'h1C);
        check("make_1C", int'(bus.ps2_key), 'h41C);
        send_byte(8'hF0);
        check("f0_no_event", int'(bus.ps2_key), 'h41C);
        send_byte(8'h1C);
        check("break_1C", int'(bus.ps2_key), 'h21C);
        check("mb_toggles", toggles - t0, 2);

        // Extended make / break
        t0 = toggles;
        send_byte(8'hE0);
        send_byte(8'h75);
        check("ext_make", int'(bus.ps2_key), 'h575);
        send_byte(8'hE0);
        send_byte(8'hF0);
        check("ext_pending", int'(bus.ps2_key), 'h575);
        send_byte(8'h75);
        check("ext_break", int'(bus.ps2_key), 'h375);
        check("ext_toggles", toggles - t0, 2);
        check("no_ferr_yet", fe_pulses, 0);

        // Parity error on a plain byte
        t0 = toggles; f0 = fe_pulses; h0 = fe_hi;
        send_byte(8'h1C, 1'b1);
        check("perr_pulses", fe_pulses - f0, 1);
        check("perr_width", fe_hi - h0, 1);
        check("perr_key_hold", int'(bus.ps2_key), 'h375);
        send_byte(8'h1C);
        check("perr_recover", int'(bus.ps2_key), 'h41C);
        check("perr_toggles", toggles - t0, 1);

        // Parity error on F0 drops the break prefix
        f0 = fe_pulses;
        send_byte(8'hF0, 1'b1);
        check("perr_f0_pulse", fe_pulses - f0, 1);
        send_byte(8'h1C);
        check("perr_f0_make", int'(bus.ps2_key), 'h01C);

        // Timeout: start + 4 data bits, then the clock stays high
        f0 = fe_pulses;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        bus.ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        lat = 0; got = 1'b0; busy_mid = 1'b0;
        while (lat < TIMEOUT + FILTER + 40 && !got) begin
            @(negedge clk);
            lat++;
            if (lat == HALF) bus.ps2_clk = 1'b1;
            if (lat == 5) busy_mid = bus.busy;
            if (bus.frame_err === 1'b1) got = 1'b1;
        end
        check("tout_busy_mid", int'(busy_mid), 1);
        check("tout_seen", int'(got), 1);
        check("tout_latency", lat, TIMEOUT + FILTER + 2);
        check("tout_busy_low", int'(bus.busy), 0);
        @(negedge clk);
        check("tout_ferr_1cyc", int'(bus.frame_err), 0);
        check("tout_pulses", fe_pulses - f0, 1);
        repeat (2 * HALF) @(negedge clk);
        send_byte(8'h29);
        check("tout_recover", int'(bus.ps2_key), 'h429);

        // Pause sequence and controller response are silent
        t0 = toggles;
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        check("pause_silent", toggles - t0, 0);
        send_byte(8'hAA);
        check("aa_silent", int'(bus.ps2_key), 'h429);
        send_byte(8'h5A);
        check("pause_5A", int'(bus.ps2_key), 'h05A);
        check("pause_toggles", toggles - t0, 1);

        // Glitches on an idle clock, then a glitchy but valid frame
        f0 = fe_pulses;
        for (int i = 0; i < 3; i++) begin
            bus.ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        check("glitch_idle_busy", int'(bus.busy), 0);
        check("glitch_idle_ferr", fe_pulses - f0, 0);
        t0 = toggles;
        send_byte(8'h1C, 1'b0, 1'b1);
        check("glitch_frame", int'(bus.ps2_key), 'h41C);
        check("glitch_toggles", toggles - t0, 1);
        check("glitch_ferr", fe_pulses - f0, 0);

        // Reset in the middle of a frame with E0 pending
        send_byte(8'hE0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        reset = 1'b0;
        #1;
        check("midrst_key", int'(bus.ps2_key), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_ferr", int'(bus.frame_err), 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        t0 = toggles;
        send_byte(8'h1C);
        check("midrst_recover", int'(bus.ps2_key), 'h41C);
        check("midrst_toggles", toggles - t0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
